// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one word per line.
// Define DCACHE_EN to build the tag/data/valid arrays; otherwise every access goes to the controller.
module dcache #(
  parameter int          INDEX_WIDTH = 6,
  parameter logic [31:0] IO_BASE     = 32'h0003_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_c,
  input  logic        wr_c,
  input  logic [31:0] data_write_c,
  input  logic [1:0]  memcnf_c,
  output logic [31:0] data_c,
  output logic        data_available_c,
  output logic        mc_req,
  output logic        mc_wr,
  output logic [31:0] mc_addr,
  output logic [31:0] mc_wdata,
  output logic [1:0]  mc_cnf,
  input  logic [31:0] mc_rdata,
  input  logic        mc_done
);
  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  off_q, off_d;
  logic        cach_q, cach_d;
  logic [31:0] data_q, data_d;
  logic        mc_req_q, mc_req_d;
  logic        mc_wr_q, mc_wr_d;
  logic [31:0] mc_addr_q, mc_addr_d;
  logic [31:0] mc_wdata_q, mc_wdata_d;
  logic [1:0]  mc_cnf_q, mc_cnf_d;
  logic        lkp_hit;
  logic [31:0] lkp_line;

`ifdef DCACHE_EN
  localparam int LINES = 1 << INDEX_WIDTH;
  localparam int TAG_W = 30 - INDEX_WIDTH;
  localparam bit CACHE_ON = 1'b1;

  logic [LINES-1:0]       valid_q, valid_d;
  logic [TAG_W-1:0]       tag_q [LINES];
  logic [31:0]            line_q [LINES];
  logic                   hit_q, hit_d;
  logic                   fill_we;
  logic [31:0]            fill_line;
  logic [INDEX_WIDTH-1:0] req_idx, cur_idx;

  // The controller address keeps the index/tag bits for both aligned fills and exact stores.
  assign req_idx  = addr_c[INDEX_WIDTH+1:2];
  assign cur_idx  = mc_addr_q[INDEX_WIDTH+1:2];
  assign lkp_hit  = valid_q[req_idx] && (tag_q[req_idx] == addr_c[31:INDEX_WIDTH+2]) &&
                    (addr_c < IO_BASE);
  assign lkp_line = line_q[req_idx];

  function automatic logic [31:0] merge_store(input logic [31:0] line, input logic [31:0] wd,
                                              input logic [1:0] cnf, input logic [1:0] off);
    logic [3:0]  be;
    logic [31:0] sd;
    logic [31:0] res;
    be  = (cnf == 2'd1) ? 4'b0001 : (cnf == 2'd2) ? 4'b0011 : 4'b1111;
    be  = be << off;
    sd  = wd << {off, 3'b000};
    res = line;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = sd[8*b +: 8];
    end
    return res;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst && fill_we) begin
      line_q[cur_idx] <= fill_line;
      tag_q[cur_idx]  <= mc_addr_q[31:INDEX_WIDTH+2];
    end
  end
`else
  localparam bit CACHE_ON = 1'b0;
  assign lkp_hit  = 1'b0;
  assign lkp_line = 32'd0;
`endif

  assign data_c           = data_q;
  assign data_available_c = (state_q == RESP);
  assign mc_req           = mc_req_q;
  assign mc_wr            = mc_wr_q;
  assign mc_addr          = mc_addr_q;
  assign mc_wdata         = mc_wdata_q;
  assign mc_cnf           = mc_cnf_q;

  always_comb begin
    state_d    = state_q;
    off_d      = off_q;
    cach_d     = cach_q;
    data_d     = data_q;
    mc_req_d   = mc_req_q;
    mc_wr_d    = mc_wr_q;
    mc_addr_d  = mc_addr_q;
    mc_wdata_d = mc_wdata_q;
    mc_cnf_d   = mc_cnf_q;
`ifdef DCACHE_EN
    hit_d      = hit_q;
    fill_we    = 1'b0;
    fill_line  = mc_rdata;
`endif
    case (state_q)
      IDLE: begin
        if (memcnf_c != 2'd0) begin
          off_d  = addr_c[1:0];
          cach_d = CACHE_ON && (addr_c < IO_BASE);
`ifdef DCACHE_EN
          hit_d  = lkp_hit;
`endif
          if (!wr_c && lkp_hit) begin
            state_d = RESP;
            data_d  = lkp_line >> {addr_c[1:0], 3'b000};
          end else begin
            mc_req_d   = 1'b1;
            mc_wr_d    = wr_c;
            mc_wdata_d = wr_c ? data_write_c : 32'd0;
            mc_addr_d  = addr_c;
            mc_cnf_d   = memcnf_c;
            state_d    = wr_c ? WR_WAIT : RD_WAIT;
            // Cacheable load misses fetch the whole line.
            if (!wr_c && CACHE_ON && (addr_c < IO_BASE)) begin
              mc_addr_d = {addr_c[31:2], 2'b00};
              mc_cnf_d  = 2'd3;
            end
          end
        end
      end
      RD_WAIT: begin
        if (mc_done) begin
          mc_req_d = 1'b0;
          state_d  = RESP;
          data_d   = cach_q ? (mc_rdata >> {off_q, 3'b000}) : mc_rdata;
`ifdef DCACHE_EN
          fill_we  = cach_q;
`endif
        end
      end
      WR_WAIT: begin
        if (mc_done) begin
          mc_req_d = 1'b0;
          mc_wr_d  = 1'b0;
          state_d  = RESP;
          data_d   = 32'd0;
`ifdef DCACHE_EN
          fill_we   = hit_q;
          fill_line = merge_store(line_q[cur_idx], mc_wdata_q, mc_cnf_q, off_q);
`endif
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef DCACHE_EN
    valid_d = valid_q;
    if (fill_we) valid_d[cur_idx] = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      off_q      <= 2'd0;
      cach_q     <= 1'b0;
      data_q     <= 32'd0;
      mc_req_q   <= 1'b0;
      mc_wr_q    <= 1'b0;
      mc_addr_q  <= 32'd0;
      mc_wdata_q <= 32'd0;
      mc_cnf_q   <= 2'd0;
`ifdef DCACHE_EN
      valid_q    <= '0;
      hit_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      off_q      <= off_d;
      cach_q     <= cach_d;
      data_q     <= data_d;
      mc_req_q   <= mc_req_d;
      mc_wr_q    <= mc_wr_d;
      mc_addr_q  <= mc_addr_d;
      mc_wdata_q <= mc_wdata_d;
      mc_cnf_q   <= mc_cnf_d;
`ifdef DCACHE_EN
      valid_q    <= valid_d;
      hit_q      <= hit_d;
`endif
    end
  end
endmodule

// File: tb/tb_dcache.sv
// Directed and randomized bench for dcache against a line-array reference model.
module tb_dcache;
`ifdef DCACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif
  localparam int          LINES   = 64;
  localparam logic [31:0] IO_BASE = 32'h0003_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr_c = 32'd0;
  logic        wr_c = 1'b0;
  logic [31:0] data_write_c = 32'd0;
  logic [1:0]  memcnf_c = 2'd0;
  logic [31:0] data_c;
  logic        data_available_c;
  logic        mc_req;
  logic        mc_wr;
  logic [31:0] mc_addr;
  logic [31:0] mc_wdata;
  logic [1:0]  mc_cnf;
  logic [31:0] mc_rdata = 32'd0;
  logic        mc_done = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: per-line valid flag, full word address held, and line contents.
  bit          m_valid [LINES];
  logic [29:0] m_waddr [LINES];
  logic [31:0] m_line  [LINES];

  dcache dut (
    .clk(clk), .rst(rst), .addr_c(addr_c), .wr_c(wr_c), .data_write_c(data_write_c),
    .memcnf_c(memcnf_c), .data_c(data_c), .data_available_c(data_available_c),
    .mc_req(mc_req), .mc_wr(mc_wr), .mc_addr(mc_addr), .mc_wdata(mc_wdata),
    .mc_cnf(mc_cnf), .mc_rdata(mc_rdata), .mc_done(mc_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endtask

  // One complete transaction; dly is the number of extra cycles before mc_done.
  task automatic do_req(input logic [31:0] a, input bit w, input logic [31:0] wd,
                        input logic [1:0] cnf, input logic [31:0] rd, input int dly);
    int          ix;
    int          nbytes;
    int          off;
    bit          cach;
    bit          hit;
    logic [31:0] exp_addr;
    logic [1:0]  exp_cnf;
    logic [31:0] exp_data;
    off  = int'(a[1:0]);
    ix   = int'((a / 4) % LINES);
    cach = CACHE_ON && (a < IO_BASE);
    hit  = cach && m_valid[ix] && (m_waddr[ix] == a[31:2]);
    addr_c = a; wr_c = w; data_write_c = wd; memcnf_c = cnf;
    next_cycle();
    addr_c = $urandom; wr_c = 1'($urandom); data_write_c = $urandom;
    if (!w && hit) begin
      memcnf_c = 2'd0;
      exp_data = m_line[ix] >> (8 * off);
      chk("hit_dav", 32'(data_available_c), 32'd1);
      chk("hit_noreq", 32'(mc_req), 32'd0);
      chk("hit_data", data_c, exp_data);
    end else begin
      memcnf_c = 2'($urandom_range(1, 3));
      if (!w && cach) begin
        exp_addr = a & ~32'd3;
        exp_cnf  = 2'd3;
      end else begin
        exp_addr = a;
        exp_cnf  = cnf;
      end
      chk("req_rise", 32'(mc_req), 32'd1);
      chk("req_wr", 32'(mc_wr), 32'(w));
      chk("req_addr", mc_addr, exp_addr);
      chk("req_cnf", 32'(mc_cnf), 32'(exp_cnf));
      if (w) chk("req_wdata", mc_wdata, wd);
      for (int i = 0; i < dly; i++) begin
        next_cycle();
        chk("req_hold", 32'(mc_req), 32'd1);
        chk("wait_nodav", 32'(data_available_c), 32'd0);
      end
      mc_done = 1'b1; mc_rdata = rd;
      next_cycle();
      mc_done = 1'b0; mc_rdata = $urandom; memcnf_c = 2'd0;
      if (w) begin
        exp_data = 32'd0;
        if (hit) begin
          nbytes = (cnf == 2'd1) ? 1 : (cnf == 2'd2) ? 2 : 4;
          for (int b = 0; b < nbytes; b++)
            if (off + b < 4) m_line[ix][8*(off+b) +: 8] = wd[8*b +: 8];
        end
      end else if (cach) begin
        m_valid[ix] = 1'b1;
        m_waddr[ix] = a[31:2];
        m_line[ix]  = rd;
        exp_data    = rd >> (8 * off);
      end else begin
        exp_data = rd;
      end
      chk("done_dav", 32'(data_available_c), 32'd1);
      chk("done_reqdrop", 32'(mc_req), 32'd0);
      chk("done_data", data_c, exp_data);
    end
    next_cycle();
    chk("dav_pulse", 32'(data_available_c), 32'd0);
    chk("idle_noreq", 32'(mc_req), 32'd0);
    chk("data_hold", data_c, exp_data);
  endtask

  logic [31:0] base;
  logic [31:0] ra;
  logic [1:0]  rc;
  logic [1:0]  roff;

  initial begin
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_data", data_c, 32'd0);
    chk("rst_dav", 32'(data_available_c), 32'd0);
    chk("rst_req", 32'(mc_req), 32'd0);
    chk("rst_wr", 32'(mc_wr), 32'd0);
    chk("rst_addr", mc_addr, 32'd0);
    chk("rst_wdata", mc_wdata, 32'd0);
    chk("rst_cnf", 32'(mc_cnf), 32'd0);

    // Stray completion while idle must be ignored.
    mc_done = 1'b1; mc_rdata = 32'h1234_5678;
    next_cycle();
    mc_done = 1'b0;
    chk("stray_req", 32'(mc_req), 32'd0);
    chk("stray_dav", 32'(data_available_c), 32'd0);
    next_cycle();
    chk("stray_dav2", 32'(data_available_c), 32'd0);
    chk("stray_data", data_c, 32'd0);

    do_req(32'h100, 1'b0, 32'd0, 2'd3, 32'hDEAD_BEEF, 2);
    do_req(32'h100, 1'b0, 32'd0, 2'd3, 32'hDEAD_BEEF, 0);
    do_req(32'h103, 1'b0, 32'd0, 2'd1, 32'hDEAD_BEEF, 1);
    do_req(32'h102, 1'b0, 32'd0, 2'd2, 32'hDEAD_BEEF, 0);
    do_req(32'h101, 1'b1, 32'h55, 2'd1, $urandom, 1);
    do_req(32'h100, 1'b0, 32'd0, 2'd3, 32'hDEAD_55EF, 0);
    do_req(32'h200, 1'b1, 32'd1, 2'd3, $urandom, 0);
    do_req(32'h200, 1'b0, 32'd0, 2'd3, 32'h0000_0001, 1);
    do_req(32'h30004, 1'b0, 32'd0, 2'd1, $urandom, 0);
    do_req(32'h30004, 1'b0, 32'd0, 2'd1, $urandom, 2);

    // Reset while waiting for a read; the late completion must be discarded.
    addr_c = 32'h108; wr_c = 1'b0; memcnf_c = 2'd3;
    next_cycle();
    memcnf_c = 2'd0;
    chk("rstmid_req", 32'(mc_req), 32'd1);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    clear_model();
    chk("rstmid_drop", 32'(mc_req), 32'd0);
    chk("rstmid_nodav", 32'(data_available_c), 32'd0);
    mc_done = 1'b1; mc_rdata = 32'hCAFE_F00D;
    next_cycle();
    mc_done = 1'b0;
    chk("rstmid_ignore", 32'(data_available_c), 32'd0);
    chk("rstmid_noreq", 32'(mc_req), 32'd0);
    next_cycle();
    do_req(32'h100, 1'b0, 32'd0, 2'd3, $urandom, 1);

    for (int n = 0; n < 250; n++) begin
      case ($urandom_range(0, 6))
        0: base = 32'h100;
        1: base = 32'h104;
        2: base = 32'h200;
        3: base = 32'h1F0;
        4: base = 32'h2FFFC;
        5: base = 32'h30000;
        default: base = 32'h30004;
      endcase
      rc = 2'($urandom_range(1, 3));
      if (rc == 2'd3) roff = 2'd0;
      else if (rc == 2'd2) roff = {1'($urandom_range(0, 1)), 1'b0};
      else roff = 2'($urandom_range(0, 3));
      ra = base | {30'd0, roff};
      do_req(ra, 1'($urandom), $urandom, rc, $urandom, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
